// File: rtl/ru_arb_pkg.sv
// ----------------------------------------------------------------------------
// ru_arb_pkg
//   Shared types for the ru_ram arbiter (ru_mem_arbiter and ru_arb_pick).
//
//   arb_state_t : which port currently owns the RAM.
//     IDLE  - nobody owns it; RAM outputs are driven to zero.
//     GNT_I - the instruction-fetch port owns it (read only).
//     GNT_D - the load/store port owns it (read or write).
// ----------------------------------------------------------------------------
package ru_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_t;

endpackage : ru_arb_pkg

// File: rtl/ru_arb_pick.sv
// ----------------------------------------------------------------------------
// ru_arb_pick
//   Combinational grant selection used when the arbiter is idle. Given the two
//   level requests and which port was served last, returns the grant state to
//   enter on the next edge (IDLE when nothing is requesting).
//
//   Build option (macro RU_ARB_RR_EN):
//     defined   - round-robin on contention: the port not served last wins.
//     undefined - fixed priority on contention: the load/store port wins;
//                 last_d is accepted but not used.
//
// Ports
//   i_req  in  fetch port is requesting
//   d_req  in  load/store port is requesting
//   last_d in  1 = load/store port completed the most recent access
//   pick   out grant state to move to from IDLE
// ----------------------------------------------------------------------------
module ru_arb_pick
  import ru_arb_pkg::*;
(
  input  logic       i_req,
  input  logic       d_req,
  input  logic       last_d,
  output arb_state_t pick
);

`ifdef RU_ARB_RR_EN
  always_comb begin
    pick = IDLE;
    if (i_req && d_req) begin
      // Contention: hand the RAM to whoever did not get it last time.
      pick = last_d ? GNT_I : GNT_D;
    end else if (d_req) begin
      pick = GNT_D;
    end else if (i_req) begin
      pick = GNT_I;
    end
  end
`else
  // History is only meaningful for round-robin; keep it connected so the
  // port list is identical in both builds.
  logic unused_last_d;
  assign unused_last_d = last_d;

  always_comb begin
    pick = IDLE;
    if (d_req) begin
      // Data accesses win any tie: a stalled load blocks the pipeline harder
      // than a late fetch.
      pick = GNT_D;
    end else if (i_req) begin
      pick = GNT_I;
    end
  end
`endif

endmodule : ru_arb_pick

// File: rtl/ru_mem_arbiter.sv
// ----------------------------------------------------------------------------
// ru_mem_arbiter
//   Shares the single-ported ru_ram between the instruction-fetch port (read
//   only) and the load/store port. Each level request is turned into one
//   granted RAM access; the access completes in the first grant cycle with
//   ram_busy low, which is also the single cycle in which the matching ack
//   pulses and read data is presented.
//
//   Only the owner state and the "served last" bit are registered; every
//   output is decoded combinationally from them, so an asynchronous reset
//   clears all acks, the write enable and the RAM address immediately.
//
//   Build option: RU_ARB_RR_EN selects round-robin instead of fixed data
//   priority when both ports request while idle (see ru_arb_pick).
//
// Parameters
//   ADDR_W  byte address width to the RAM
//   DATA_W  data word width
//
// Ports
//   clk        in  system clock, rising edge
//   nRst       in  asynchronous active-low reset
//   i_req      in  fetch request, held until i_ack
//   i_addr     in  fetch address
//   i_rdata    out fetch read data, zero except in the i_ack cycle
//   i_ack      out fetch complete, one-cycle pulse
//   d_req      in  load/store request, held until d_ack
//   d_wen      in  1 = store, 0 = load
//   d_addr     in  load/store address
//   d_wdata    in  store data
//   d_rdata    out load data, zero except in the d_ack cycle
//   d_ack      out load/store complete, one-cycle pulse
//   ram_addr   out RAM address (zero while idle)
//   ram_wen    out RAM write enable
//   ram_wdata  out RAM write data (zero unless the data port owns the RAM)
//   ram_rdata  in  RAM combinational read data
//   ram_busy   in  RAM stall; an access completes only when this is low
//   grant_d    out high while the data port owns the RAM
// ----------------------------------------------------------------------------
module ru_mem_arbiter
  import ru_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              nRst,

  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,

  input  logic              d_req,
  input  logic              d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,

  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wen,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_busy,

  output logic              grant_d
);

  arb_state_t state_q, state_d;
  logic       last_d_q, last_d_d;
  arb_state_t idle_pick;

  ru_arb_pick u_pick (
    .i_req  (i_req),
    .d_req  (d_req),
    .last_d (last_d_q),
    .pick   (idle_pick)
  );

  // Next-state: leave IDLE via the picker; leave a grant only on a
  // non-busy cycle, handing over directly to the other port if it is
  // waiting. The completing port's request is still high in its ack cycle,
  // so it must never be regranted from here.
  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    case (state_q)
      IDLE: begin
        state_d = idle_pick;
      end
      GNT_I: begin
        if (!ram_busy) begin
          last_d_d = 1'b0;
          state_d  = d_req ? GNT_D : IDLE;
        end
      end
      GNT_D: begin
        if (!ram_busy) begin
          last_d_d = 1'b1;
          state_d  = i_req ? GNT_I : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
    end
  end

  // Output decode. Read data is gated to the ack cycle so a requester that
  // samples early never sees a stale or mid-stall word.
  always_comb begin
    ram_addr  = '0;
    ram_wen   = 1'b0;
    ram_wdata = '0;
    i_ack     = 1'b0;
    d_ack     = 1'b0;
    i_rdata   = '0;
    d_rdata   = '0;
    grant_d   = 1'b0;
    case (state_q)
      GNT_I: begin
        ram_addr = i_addr;
        i_ack    = !ram_busy;
        if (!ram_busy) begin
          i_rdata = ram_rdata;
        end
      end
      GNT_D: begin
        ram_addr  = d_addr;
        ram_wdata = d_wdata;
        ram_wen   = d_wen;
        grant_d   = 1'b1;
        d_ack     = !ram_busy;
        if (!ram_busy) begin
          d_rdata = ram_rdata;
        end
      end
      default: begin
      end
    endcase
  end

endmodule : ru_mem_arbiter
